sys_bus_interconnect_reg: RTL and testbench
===========================================

Name: sys_bus_interconnect_reg

Overview:
Registered, timeout-protected successor to the combinational system-bus interconnect. It decodes one master request onto one of SN slaves and issues a single-cycle strobe. It then tracks the transaction until the slave acks, the timeout expires, or decode fails, and returns a registered response. It sits between the PS/AXI bridge master and the peripheral slaves, and keeps a hung or unmapped slave from stalling the CPU.

Parameters:
SN, 16, number of slave ports (1..64, need not be a power of 2)
SW, 20, slave address width; slave index = addr[SW +: SL], SL = max(1, $clog2(SN))
SM, '1 (SN bits), slave map; bit i = 0 means slave i is unmapped
TW, 8, timeout counter width
TO, 255, timeout in cycles after the strobe (1 .. 2**TW-1)

Ports:
clk_i, input, 1, system clock
rst_i, input, 1, synchronous active-high reset
bus_m, sys_bus_if.s, -, from master (addr 32, wdata 32, wen, ren, rdata 32, err, ack)
bus_s[SN-1:0], sys_bus_if.m, -, to slaves
busy_o, output, 1, transaction in flight (state != IDLE)
timeout_o, output, 1, one-cycle pulse when a transaction times out
drop_o, output, 1, one-cycle pulse when a master strobe is ignored because the block is busy

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on rst_i.
- On reset:
  - state = IDLE, counter = 0.
  - bus_m.ack, bus_m.err, bus_m.rdata = 0.
  - All bus_s[i].wen and ren = 0; latched addr and wdata = 0.
  - busy_o, timeout_o, drop_o = 0.
- Reset mid-transaction aborts without a master response. Slave acks arriving after reset are ignored.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE, on a cycle where bus_m.wen | bus_m.ren:
  - Latch addr, wdata, index, op → REQ.
  - Also latch a decode-error flag, set if any of: wen & ren together, index >= SN, SM[index] = 0.
- REQ (exactly 1 cycle):
  - If the decode error is clear, drive the selected slave's wen or ren = 1. All other strobes stay 0.
  - If the decode error is set, drive no strobe → RESP with err = 1, rdata = 0.
  - Else if the selected slave's ack = 1 in this cycle → RESP. Capture rdata and err.
  - Else → WAIT, counter = 1.
- WAIT:
  - Strobes are 0.
  - On the selected slave's ack → RESP. Capture rdata and err.
  - Else, if counter == TO → RESP with err = 1, rdata = 0, and pulse timeout_o.
  - Else counter++.
  - If ack and timeout happen in the same cycle, ack wins (no timeout).
- RESP (1 cycle): bus_m.ack = 1, with registered rdata and err → IDLE.
- bus_m.ack, err and rdata are registered. rdata and err are valid only while ack = 1; otherwise they are driven to 0.
- Latency for a combinational slave (acks in the strobe cycle): request at cycle n → strobe at n+1 → master ack at n+2.
- Latency for decode error: master ack at n+2.
- Latency for timeout: master ack at n+2+TO.
- bus_s[i].addr and wdata are driven to all slaves from the latched registers. They are stable from REQ until return to IDLE.
- Non-selected slaves' acks are ignored. Acks received in IDLE or RESP are ignored.
- A master strobe seen in REQ, WAIT or RESP is not queued; drop_o pulses. The master must wait for ack (single outstanding transaction).
- A new request is accepted in the IDLE cycle immediately after RESP.
- Index width: addr bits above SW+SL are ignored (wrap). The index compare against SN is done at width SL.

Decomposition:
- Package sys_bus_pkg:
  - typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} sys_bus_state_t
  - localparam DW = 32, AW = 32
  - function sys_bus_sl(SN) returning max(1, $clog2(SN))
- Sub-module sys_bus_timer (TW, TO): clear, enable, expired. It is the counter used in WAIT.
- The decode and FSM stay in the top module.

Test Plan:
- SN=16, slave 3 acks in the strobe cycle with rdata=0xDEADBEEF; master reads addr 0x0030_0010 at cycle 0 → bus_s[3].ren=1 at cycle 1 only; bus_m.ack=1, rdata=0xDEADBEEF, err=0 at cycle 2.
- Slave 5 acks 4 cycles after the strobe; master writes 0x1234_5678 to 0x0050_0000 → bus_s[5].wen is a 1-cycle pulse; wdata holds 0x12345678 throughout; master ack at strobe+5.
- SN=12 with SM bit 2 = 0; access index 2, then index 14 → no slave strobe in either case; master ack with err=1, rdata=0 two cycles after each request.
- TO=8 with a slave that never acks → timeout_o and bus_m.ack/err=1 at request+10; a late slave ack at request+12 is ignored, and the next read completes normally.
- Second master strobe during WAIT → drop_o pulses once, no additional slave strobe; first transaction completes. Same scenario with wen&ren asserted together → err=1, no strobe.
- rst_i asserted during WAIT → next cycle busy_o=0 and all strobes/ack=0; no master ack follows; a fresh read afterwards completes with the expected latency.

Source files
------------

// File: rtl/sys_bus_pkg.sv
`default_nettype none
// ============================================================================
// sys_bus_pkg : shared types, widths and helpers for the system-bus interconnect
// Revision    : 1.0
// ============================================================================
package sys_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } sys_bus_state_t;

    localparam int DW = 32;
    localparam int AW = 32;

    // Slave-index width; a single slave still needs one index bit.
    function automatic int sys_bus_sl(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sys_bus_if.sv
`default_nettype none
// ============================================================================
// sys_bus_if : simple strobe/ack system-bus bundle (m = initiator, s = target)
// Revision   : 1.0
// ============================================================================
interface sys_bus_if;
    import sys_bus_pkg::*;

    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wen;
    logic          ren;
    logic [DW-1:0] rdata;
    logic          err;
    logic          ack;

    modport m (output addr, wdata, wen, ren, input rdata, err, ack);
    modport s (input addr, wdata, wen, ren, output rdata, err, ack);
endinterface
`default_nettype wire

// File: rtl/sys_bus_timer.sv
`default_nettype none
// ============================================================================
// sys_bus_timer : wait-state counter that flags when TO cycles have elapsed
// Revision      : 1.0
// ============================================================================
module sys_bus_timer #(
    parameter int TW = 8,
    parameter int TO = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TW-1:0] r_cnt;

    // clear restarts at 1: the first wait cycle is already one cycle past the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= TW'(1);
        end else if (enable && !expired) begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

    assign expired = (r_cnt == TW'(TO));

endmodule
`default_nettype wire

// File: rtl/sys_bus_interconnect_reg.sv
`default_nettype none
// ============================================================================
// sys_bus_interconnect_reg : registered, timeout-protected 1-to-SN bus decoder
// Revision                 : 1.0
// ============================================================================
module sys_bus_interconnect_reg
    import sys_bus_pkg::*;
#(
    parameter int            SN = 16,
    parameter int            SW = 20,
    parameter logic [SN-1:0] SM = '1,
    parameter int            TW = 8,
    parameter int            TO = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    sys_bus_if.s bus_m,
    sys_bus_if.m bus_s [SN-1:0],
    output logic busy_o,
    output logic timeout_o,
    output logic drop_o
);

    localparam int             SL    = sys_bus_sl(SN);
    localparam int             NP    = 1 << SL;
    // Map padded to the full index range, so out-of-range indices read as unmapped.
    localparam logic [NP-1:0]  C_MAP = NP'(SM);

    sys_bus_state_t r_state;
    logic [AW-1:0]  r_addr;
    logic [DW-1:0]  r_wdata;
    logic [SL-1:0]  r_idx;
    logic           r_derr;
    logic [SN-1:0]  r_wen;
    logic [SN-1:0]  r_ren;
    logic           r_ack;
    logic           r_err;
    logic [DW-1:0]  r_rdata;
    logic           r_timeout;
    logic           r_drop;

    logic [SL-1:0]  w_idx;
    logic           w_req;
    logic           w_derr;
    logic [NP-1:0]  w_sel;
    logic [NP-1:0]  w_ack;
    logic [NP-1:0]  w_serr;
    logic [DW-1:0]  w_srdata [NP];
    logic           w_expired;

    assign w_idx  = bus_m.addr[SW +: SL];
    assign w_req  = bus_m.wen | bus_m.ren;
    assign w_derr = (bus_m.wen & bus_m.ren) | ~C_MAP[w_idx];
    assign w_sel  = NP'(1) << w_idx;

    for (genvar g = 0; g < NP; g++) begin : g_slave
        if (g < SN) begin : g_port
            assign bus_s[g].addr  = r_addr;
            assign bus_s[g].wdata = r_wdata;
            assign bus_s[g].wen   = r_wen[g];
            assign bus_s[g].ren   = r_ren[g];
            assign w_ack[g]       = bus_s[g].ack;
            assign w_serr[g]      = bus_s[g].err;
            assign w_srdata[g]    = bus_s[g].rdata;
        end else begin : g_pad
            assign w_ack[g]       = 1'b0;
            assign w_serr[g]      = 1'b0;
            assign w_srdata[g]    = '0;
        end
    end

    sys_bus_timer #(
        .TW (TW),
        .TO (TO)
    ) u_timer (
        .clk     (clk_i),
        .rst     (rst_i),
        .clear   (r_state == REQ),
        .enable  (r_state == WAIT),
        .expired (w_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_idx     <= '0;
            r_derr    <= 1'b0;
            r_wen     <= '0;
            r_ren     <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_timeout <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_wen     <= '0;
            r_ren     <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_timeout <= 1'b0;
            r_drop    <= (r_state != IDLE) && w_req;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr  <= bus_m.addr;
                        r_wdata <= bus_m.wdata;
                        r_idx   <= w_idx;
                        r_derr  <= w_derr;
                        r_wen   <= w_derr ? '0 : (w_sel[SN-1:0] & {SN{bus_m.wen}});
                        r_ren   <= w_derr ? '0 : (w_sel[SN-1:0] & {SN{bus_m.ren}});
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (r_derr) begin
                        r_ack   <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end else if (w_ack[r_idx]) begin
                        r_ack   <= 1'b1;
                        r_err   <= w_serr[r_idx];
                        r_rdata <= w_srdata[r_idx];
                        r_state <= RESP;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    // A slave ack in the expiry cycle takes priority over the timeout.
                    if (w_ack[r_idx]) begin
                        r_ack   <= 1'b1;
                        r_err   <= w_serr[r_idx];
                        r_rdata <= w_srdata[r_idx];
                        r_state <= RESP;
                    end else if (w_expired) begin
                        r_ack     <= 1'b1;
                        r_err     <= 1'b1;
                        r_timeout <= 1'b1;
                        r_state   <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus_m.ack   = r_ack;
    assign bus_m.err   = r_err;
    assign bus_m.rdata = r_rdata;
    assign busy_o      = (r_state != IDLE);
    assign timeout_o   = r_timeout;
    assign drop_o      = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_sys_bus_interconnect_reg.sv
`default_nettype none
// ============================================================================
// tb_sys_bus_interconnect_reg : directed self-checking bench (SN=12, slave 2 unmapped, TO=8)
// Revision                    : 1.0
// ============================================================================
module tb_sys_bus_interconnect_reg;

    localparam int SN = 12;

    logic clk;
    logic rst;
    logic busy, tmo, drop;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [SN-1:0] comb_mask;
    logic [SN-1:0] man_ack;
    logic [SN-1:0] s_err;
    logic [31:0]   s_rdata [SN];
    logic [SN-1:0] s_wen, s_ren;
    logic [31:0]   s_addr  [SN];
    logic [31:0]   s_wdata [SN];

    sys_bus_if bus_m ();
    sys_bus_if bus_s [SN-1:0] ();

    // Slave models: a comb_mask slave acks in its strobe cycle; man_ack is driven by the tests.
    for (genvar g = 0; g < SN; g++) begin : g_slv
        assign s_wen[g]       = bus_s[g].wen;
        assign s_ren[g]       = bus_s[g].ren;
        assign s_addr[g]      = bus_s[g].addr;
        assign s_wdata[g]     = bus_s[g].wdata;
        assign bus_s[g].ack   = man_ack[g] | (comb_mask[g] & (bus_s[g].wen | bus_s[g].ren));
        assign bus_s[g].err   = s_err[g];
        assign bus_s[g].rdata = s_rdata[g];
    end

    sys_bus_interconnect_reg #(
        .SN (SN),
        .SW (20),
        .SM (12'hFFB),
        .TW (8),
        .TO (8)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus_m     (bus_m),
        .bus_s     (bus_s),
        .busy_o    (busy),
        .timeout_o (tmo),
        .drop_o    (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        bus_m.wen = w; bus_m.ren = r; bus_m.addr = a; bus_m.wdata = d;
    endtask

    task automatic release_m();
        bus_m.wen = 1'b0; bus_m.ren = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        comb_mask = 12'h00C; man_ack = '0; s_err = '0;
        for (int i = 0; i < SN; i++) s_rdata[i] = 32'h0;
        s_rdata[2] = 32'h2222_2222;
        s_rdata[3] = 32'hDEAD_BEEF;
        s_rdata[5] = 32'h5555_AAAA;
        s_rdata[7] = 32'h7777_7777;
        cyc(2);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        n_checks++; if ({tmo, drop} !== 2'b00) begin n_errors++; $display("FAIL reset_pulses: got %b exp 00", {tmo, drop}); end
        n_checks++; if ({bus_m.ack, bus_m.err} !== 2'b00 || bus_m.rdata !== 32'h0) begin n_errors++; $display("FAIL reset_mresp: got ack/err %b rdata %h exp 00 0", {bus_m.ack, bus_m.err}, bus_m.rdata); end
        n_checks++; if (s_wen !== 12'h0 || s_ren !== 12'h0) begin n_errors++; $display("FAIL reset_strobes: got wen %h ren %h exp 0", s_wen, s_ren); end
        n_checks++; if (s_addr[0] !== 32'h0 || s_wdata[0] !== 32'h0) begin n_errors++; $display("FAIL reset_latch: got addr %h wdata %h exp 0", s_addr[0], s_wdata[0]); end
        rst = 1'b0;
    endtask

    task automatic test_comb_read();
        drive(1'b0, 1'b1, 32'h0030_0010, 32'h0);
        cyc(); release_m();
        n_checks++; if (s_ren !== 12'h008 || s_wen !== 12'h0) begin n_errors++; $display("FAIL cr_strobe: got ren %h wen %h exp 008 000", s_ren, s_wen); end
        n_checks++; if (busy !== 1'b1 || bus_m.ack !== 1'b0) begin n_errors++; $display("FAIL cr_c1: got busy %b ack %b exp 1 0", busy, bus_m.ack); end
        cyc();
        n_checks++; if (bus_m.ack !== 1'b1 || bus_m.err !== 1'b0 || bus_m.rdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL cr_resp: got ack %b err %b rdata %h exp 1 0 deadbeef", bus_m.ack, bus_m.err, bus_m.rdata); end
        n_checks++; if (s_ren !== 12'h0) begin n_errors++; $display("FAIL cr_strobe_off: got ren %h exp 000", s_ren); end
        cyc();
        n_checks++; if (bus_m.ack !== 1'b0 || bus_m.rdata !== 32'h0 || busy !== 1'b0) begin n_errors++; $display("FAIL cr_after: got ack %b rdata %h busy %b exp 0 0 0", bus_m.ack, bus_m.rdata, busy); end
    endtask

    task automatic test_delayed_write();
        int bad;
        bad = 0;
        drive(1'b1, 1'b0, 32'h0050_0000, 32'h1234_5678);
        cyc(); release_m();
        n_checks++; if (s_wen !== 12'h020 || s_ren !== 12'h0) begin n_errors++; $display("FAIL dw_strobe: got wen %h ren %h exp 020 000", s_wen, s_ren); end
        n_checks++; if (s_wdata[5] !== 32'h1234_5678 || s_addr[5] !== 32'h0050_0000) begin n_errors++; $display("FAIL dw_bus: got addr %h wdata %h exp 00500000 12345678", s_addr[5], s_wdata[5]); end
        for (int c = 2; c <= 5; c++) begin
            cyc();
            if (s_wen !== 12'h0 || s_wdata[5] !== 32'h1234_5678 || s_addr[5] !== 32'h0050_0000 || bus_m.ack !== 1'b0) bad++;
            if (c == 5) man_ack[5] = 1'b1;
        end
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL dw_wait: got %0d bad wait cycles exp 0", bad); end
        cyc(); man_ack[5] = 1'b0;
        n_checks++; if (bus_m.ack !== 1'b1 || bus_m.err !== 1'b0 || bus_m.rdata !== 32'h5555_AAAA) begin n_errors++; $display("FAIL dw_resp: got ack %b err %b rdata %h exp 1 0 5555aaaa", bus_m.ack, bus_m.err, bus_m.rdata); end
        n_checks++; if (s_wdata[5] !== 32'h1234_5678) begin n_errors++; $display("FAIL dw_hold: got wdata %h exp 12345678", s_wdata[5]); end
        cyc();
        n_checks++; if (busy !== 1'b0 || bus_m.ack !== 1'b0) begin n_errors++; $display("FAIL dw_after: got busy %b ack %b exp 0 0", busy, bus_m.ack); end
    endtask

    task automatic test_decode_err();
        logic [31:0] addrs [2];
        addrs[0] = 32'h0020_0000;
        addrs[1] = 32'h00E0_0000;
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, addrs[k], 32'h0);
            cyc(); release_m();
            n_checks++; if (s_ren !== 12'h0 || s_wen !== 12'h0) begin n_errors++; $display("FAIL de_strobe%0d: got ren %h wen %h exp 0", k, s_ren, s_wen); end
            cyc();
            n_checks++; if (bus_m.ack !== 1'b1 || bus_m.err !== 1'b1 || bus_m.rdata !== 32'h0) begin n_errors++; $display("FAIL de_resp%0d: got ack %b err %b rdata %h exp 1 1 0", k, bus_m.ack, bus_m.err, bus_m.rdata); end
            cyc();
        end
    endtask

    task automatic test_timeout();
        drive(1'b0, 1'b1, 32'h0070_0000, 32'h0);
        cyc(); release_m();
        n_checks++; if (s_ren !== 12'h080) begin n_errors++; $display("FAIL to_strobe: got ren %h exp 080", s_ren); end
        cyc(8);
        n_checks++; if (bus_m.ack !== 1'b0 || tmo !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL to_early: got ack %b tmo %b busy %b exp 0 0 1", bus_m.ack, tmo, busy); end
        cyc();
        n_checks++; if (tmo !== 1'b1 || bus_m.ack !== 1'b1 || bus_m.err !== 1'b1 || bus_m.rdata !== 32'h0) begin n_errors++; $display("FAIL to_resp: got tmo %b ack %b err %b rdata %h exp 1 1 1 0", tmo, bus_m.ack, bus_m.err, bus_m.rdata); end
        cyc();
        n_checks++; if (tmo !== 1'b0 || bus_m.ack !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL to_after: got tmo %b ack %b busy %b exp 0 0 0", tmo, bus_m.ack, busy); end
        cyc(); man_ack[7] = 1'b1;
        cyc(); man_ack[7] = 1'b0;
        n_checks++; if (bus_m.ack !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL to_late_ack: got ack %b busy %b exp 0 0", bus_m.ack, busy); end
        drive(1'b0, 1'b1, 32'h0030_0010, 32'h0);
        cyc(); release_m();
        cyc();
        n_checks++; if (bus_m.ack !== 1'b1 || bus_m.err !== 1'b0 || bus_m.rdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL to_next: got ack %b err %b rdata %h exp 1 0 deadbeef", bus_m.ack, bus_m.err, bus_m.rdata); end
        cyc();
    endtask

    task automatic test_drop();
        drive(1'b0, 1'b1, 32'h0050_0000, 32'h0);
        cyc(); release_m();
        n_checks++; if (s_ren !== 12'h020) begin n_errors++; $display("FAIL dr_strobe: got ren %h exp 020", s_ren); end
        cyc(2);
        drive(1'b0, 1'b1, 32'h0030_0010, 32'h0);
        cyc(); release_m();
        n_checks++; if (drop !== 1'b1 || s_ren !== 12'h0) begin n_errors++; $display("FAIL dr_pulse: got drop %b ren %h exp 1 000", drop, s_ren); end
        cyc();
        n_checks++; if (drop !== 1'b0) begin n_errors++; $display("FAIL dr_once: got drop %b exp 0", drop); end
        man_ack[5] = 1'b1;
        cyc(); man_ack[5] = 1'b0;
        n_checks++; if (bus_m.ack !== 1'b1 || bus_m.err !== 1'b0 || bus_m.rdata !== 32'h5555_AAAA || s_ren !== 12'h0) begin n_errors++; $display("FAIL dr_resp: got ack %b err %b rdata %h ren %h exp 1 0 5555aaaa 000", bus_m.ack, bus_m.err, bus_m.rdata, s_ren); end
        cyc();
        drive(1'b1, 1'b1, 32'h0030_0010, 32'h0000_0099);
        cyc(); release_m();
        n_checks++; if (s_ren !== 12'h0 || s_wen !== 12'h0) begin n_errors++; $display("FAIL rw_strobe: got ren %h wen %h exp 0", s_ren, s_wen); end
        cyc();
        n_checks++; if (bus_m.ack !== 1'b1 || bus_m.err !== 1'b1 || bus_m.rdata !== 32'h0) begin n_errors++; $display("FAIL rw_resp: got ack %b err %b rdata %h exp 1 1 0", bus_m.ack, bus_m.err, bus_m.rdata); end
        cyc();
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        drive(1'b0, 1'b1, 32'h0070_0000, 32'h0);
        cyc(); release_m();
        cyc(2);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL rm_busy: got %b exp 1", busy); end
        rst = 1'b1;
        cyc(); rst = 1'b0;
        n_checks++; if (busy !== 1'b0 || s_ren !== 12'h0 || s_wen !== 12'h0 || bus_m.ack !== 1'b0) begin n_errors++; $display("FAIL rm_abort: got busy %b ren %h wen %h ack %b exp 0", busy, s_ren, s_wen, bus_m.ack); end
        man_ack[7] = 1'b1;
        cyc(); man_ack[7] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus_m.ack !== 1'b0 || busy !== 1'b0 || tmo !== 1'b0) bad++;
            cyc();
        end
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL rm_quiet: got %0d active cycles exp 0", bad); end
        drive(1'b0, 1'b1, 32'h0030_0010, 32'h0);
        cyc(); release_m();
        cyc();
        n_checks++; if (bus_m.ack !== 1'b1 || bus_m.rdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL rm_fresh: got ack %b rdata %h exp 1 deadbeef", bus_m.ack, bus_m.rdata); end
        cyc();
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 32'h0030_0010, 32'h0);
        cyc(); release_m();
        cyc();
        n_checks++; if (bus_m.ack !== 1'b1) begin n_errors++; $display("FAIL bb_first: got ack %b exp 1", bus_m.ack); end
        cyc();
        s_rdata[3] = 32'h0123_4567;
        drive(1'b0, 1'b1, 32'h0130_0010, 32'h0);
        cyc(); release_m();
        n_checks++; if (s_ren !== 12'h008 || drop !== 1'b0) begin n_errors++; $display("FAIL bb_accept: got ren %h drop %b exp 008 0", s_ren, drop); end
        cyc();
        n_checks++; if (bus_m.ack !== 1'b1 || bus_m.rdata !== 32'h0123_4567) begin n_errors++; $display("FAIL bb_resp: got ack %b rdata %h exp 1 01234567", bus_m.ack, bus_m.rdata); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_comb_read();
        test_delayed_write();
        test_decode_err();
        test_timeout();
        test_drop();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
